// File: rtl/runctrl_pkg.sv
// runctrl_pkg: shared types for the core run controller.
//   cmd_op_e : 3-bit host command codes (code 7 is unassigned and always illegal)
//   state_e  : run controller sequencer states
package runctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RUN    = 3'd1,
    OP_HALT   = 3'd2,
    OP_STEP   = 3'd3,
    OP_MEM_RD = 3'd4,
    OP_MEM_WR = 3'd5,
    OP_SET_BP = 3'd6
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_HALTED = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_MEM    = 3'd4
  } state_e;

endpackage

// File: rtl/core_run_controller.sv
// core_run_controller: run/halt/step sequencer and data-RAM arbiter for the
// RV32I single-cycle core.
//
// Optional feature macro: RUNCTRL_BREAKPOINT_EN (PC breakpoint register).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready host command handshake
//   cmd_op/addr/wdata   command fields, latched on accept
//   rsp_valid/err/data  one response pulse per accepted command (plus one
//                       unsolicited pulse on a breakpoint hit)
//   pc                  core program counter (observed)
//   core_ram_*          core-side RAM port
//   ram_*               data RAM port (asynchronous read data)
//   core_en             PC register enable to the core
//   halted              high in HALTED
//   cycle_cnt           saturating count of cycles with core_en=1
//   dbg_state           current sequencer state
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
// rsp_valid is a one-cycle pulse that is never back-pressured.
module core_run_controller
  import runctrl_pkg::*;
#(
  parameter int RAM_DEPTH = 64,
  parameter int WORD_SIZE = 32,
  parameter int BOOT_HOLD = 4,
  parameter int CNT_WIDTH = 32,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [WORD_SIZE-1:0] rsp_data,
  input  logic [31:0]          pc,
  input  logic                 core_ram_we,
  input  logic [AW-1:0]        core_ram_addr,
  input  logic [WORD_SIZE-1:0] core_ram_wdata,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 core_en,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output state_e               dbg_state
);

  localparam int BW = $clog2(BOOT_HOLD + 1);

  state_e                 state_q, state_d;
  logic [BW-1:0]          boot_q;
  logic [2:0]             op_q;
  logic [AW-1:0]          addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic                   rsp_valid_q, rsp_err_q, rsp_live_q;
  logic [WORD_SIZE-1:0]   rsp_data_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic                   accept, bp_hit, bp_load;
  logic                   rsp_set, rsp_err_d, rsp_live_d;
  logic [WORD_SIZE-1:0]   rsp_data_d;
  logic [WORD_SIZE-1:0]   pc_word;

  assign pc_word = WORD_SIZE'(pc);

`ifdef RUNCTRL_BREAKPOINT_EN
  logic [31:0] bp_q;
  logic        bp_valid_q;

  // The gate is combinational so the core never advances past the
  // breakpoint PC. A breakpoint stays armed after it fires: resume with STEP
  // (which ignores it) before issuing RUN again.
  assign bp_hit = (state_q == ST_RUN) && bp_valid_q && (pc == bp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_q       <= '0;
      bp_valid_q <= 1'b0;
    end else if (bp_load) begin
      bp_q       <= cmd_wdata[31:0];
      bp_valid_q <= 1'b1;
    end
  end
`else
  assign bp_hit = 1'b0;
`endif

  assign core_en   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_hit;
  // Commands are refused on the breakpoint-hit cycle so the unsolicited
  // response cannot collide with a command response.
  assign cmd_ready = (state_q == ST_HALTED) || ((state_q == ST_RUN) && !bp_hit);
  assign accept    = cmd_valid && cmd_ready;
  assign halted    = (state_q == ST_HALTED);
  assign dbg_state = state_q;
  assign cycle_cnt = cnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // A STEP response reports the PC after the step; that value only exists
  // on the pc input during the response cycle itself.
  assign rsp_data  = rsp_live_q ? pc_word : rsp_data_q;

  always_comb begin
    state_d    = state_q;
    rsp_set    = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_live_d = 1'b0;
    rsp_data_d = pc_word;
    bp_load    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_q <= BW'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (accept) begin
          case (cmd_op_e'(cmd_op))
            OP_NOP, OP_HALT: rsp_set = 1'b1;
            OP_RUN: begin
              state_d = ST_RUN;
              rsp_set = 1'b1;
            end
            OP_STEP:              state_d = ST_STEP;
            OP_MEM_RD, OP_MEM_WR: state_d = ST_MEM;
            OP_SET_BP: begin
              rsp_set = 1'b1;
`ifdef RUNCTRL_BREAKPOINT_EN
              bp_load = 1'b1;
`else
              rsp_err_d = 1'b1;
`endif
            end
            default: begin
              rsp_set   = 1'b1;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_d = ST_HALTED;
          rsp_set = 1'b1;
        end else if (accept) begin
          rsp_set = 1'b1;
          if (cmd_op == OP_HALT)     state_d   = ST_HALTED;
          else if (cmd_op != OP_NOP) rsp_err_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d    = ST_HALTED;
        rsp_set    = 1'b1;
        rsp_live_d = 1'b1;
      end
      ST_MEM: begin
        state_d = ST_HALTED;
        rsp_set = 1'b1;
        if (op_q == OP_MEM_RD) rsp_data_d = ram_rdata;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      boot_q      <= BW'(BOOT_HOLD);
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_live_q  <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      if ((state_q == ST_BOOT) && (boot_q != '0)) boot_q <= boot_q - BW'(1);
      if (accept) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      rsp_valid_q <= rsp_set;
      rsp_err_q   <= rsp_err_d;
      rsp_live_q  <= rsp_live_d;
      if (rsp_set) rsp_data_q <= rsp_data_d;
      if (core_en && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Host owns the RAM only during MEM; the core cannot store while stalled.
  always_comb begin
    ram_we    = core_ram_we & core_en;
    ram_addr  = core_ram_addr;
    ram_wdata = core_ram_wdata;
    if (state_q == ST_MEM) begin
      ram_we    = (op_q == OP_MEM_WR);
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_core_run_controller.sv
`timescale 1ns/1ps
module tb_core_run_controller;
  import runctrl_pkg::*;

  localparam int AW = 6;
  localparam int WS = 32;
  localparam int CW = 32;
`ifdef RUNCTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [WS-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [WS-1:0] rsp_data;
  logic [31:0]   pc;
  logic          core_ram_we = 1'b0;
  logic [AW-1:0] core_ram_addr = '0;
  logic [WS-1:0] core_ram_wdata = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [WS-1:0] ram_wdata, ram_rdata;
  logic          core_en, halted;
  logic [CW-1:0] cycle_cnt;
  state_e        dbg_state;

  core_run_controller #(.RAM_DEPTH(64), .WORD_SIZE(WS), .BOOT_HOLD(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .pc(pc), .core_ram_we(core_ram_we), .core_ram_addr(core_ram_addr),
    .core_ram_wdata(core_ram_wdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .core_en(core_en),
    .halted(halted), .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
  );

  // ---------------- environment: core PC and data RAM ----------------
  logic [31:0] pc_base = 32'd0;
  logic [31:0] pc_off  = 32'd0;
  assign pc = pc_base + pc_off;
  always @(posedge clk) if (core_en) pc_off <= pc_off + 32'd4;

  logic [WS-1:0] ram [64];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;
  assign ram_rdata = ram[ram_addr];

  int cyc = 0;
  int we_cnt = 0;
  int en_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_we)  we_cnt <= we_cnt + 1;
    if (core_en) en_cnt <= en_cnt + 1;
  end

  task automatic set_pc(input logic [31:0] v);
    pc_base = v - pc_off;
  endtask

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad = 0;
  logic [WS-1:0] ref_mem [64];
  logic [WS-1:0] exp_q [$];
  bit            m_run = 1'b0;
  int            run_cyc = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Legality of a command given whether the core is running.
  function automatic bit exp_err_f(input bit running, input logic [2:0] op);
    if (running) return !((op == 3'd0) || (op == 3'd2));
    if (op == 3'd6) return !BP_EN;
    return (op == 3'd7);
  endfunction

  // Apply the architectural effect of a successful command to the model.
  task automatic book(input logic [2:0] op, input logic [AW-1:0] a, input logic [WS-1:0] d,
                      input bit err, input int ac);
    if (!err) begin
      if (op == 3'd5) ref_mem[a] = d;
      if (op == 3'd3) exp_cnt = exp_cnt + 1;
      if ((op == 3'd1) && !m_run) begin
        m_run = 1'b1;
        run_cyc = ac;
      end else if ((op == 3'd2) && m_run) begin
        m_run = 1'b0;
        exp_cnt = exp_cnt + CW'(ac - run_cyc);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [WS-1:0] d,
                      output logic got_err, output logic [WS-1:0] got_data,
                      output logic [31:0] acc_pc, output int acc_cyc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {63'd0, cmd_ready}, 64'd1);
    acc_pc = pc;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    got_err = rsp_err;
    got_data = rsp_data;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [WS-1:0] d);
    logic e; logic [WS-1:0] rd, xd; logic [31:0] ap; int ac; bit xe;
    xe = exp_err_f(m_run, op);
    send(op, a, d, e, rd, ap, ac);
    xd = ap;
    if (!xe && op == 3'd4) xd = ref_mem[a];
    if (!xe && op == 3'd3) xd = ap + 32'd4;
    exp_q.push_back(xd);
    chk("rand_err", {63'd0, e}, {63'd0, xe});
    chk("rand_data", {32'd0, rd}, {32'd0, exp_q.pop_front()});
    book(op, a, d, xe, ac);
    chk("rand_halted", {63'd0, halted}, {63'd0, !m_run});
  endtask

  task automatic boot_check();
    for (int i = 0; i < 4; i++) begin
      chk("boot_core_en", {63'd0, core_en}, 64'd0);
      chk("boot_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("boot_halted", {63'd0, halted}, 64'd0);
      @(negedge clk);
    end
    chk("boot_done_halted", {63'd0, halted}, 64'd1);
    chk("boot_done_ready", {63'd0, cmd_ready}, 64'd1);
    chk("boot_done_state", {61'd0, dbg_state}, {61'd0, ST_HALTED});
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_core_en"}, {63'd0, core_en}, 64'd0);
    chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
    chk({tag, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
    chk({tag, "_cycle_cnt"}, {32'd0, cycle_cnt}, 64'd0);
    chk({tag, "_ram_we"}, {63'd0, ram_we}, 64'd0);
  endtask

  // ---------------- vector table ----------------
  // kind: 0 = rsp_data is pc at accept, 1 = literal data, 2 = pc at accept + 4
  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [WS-1:0] wdata;
    bit            err;
    int            kind;
    logic [WS-1:0] data;
    bit            hlt;
  } vec_t;
  vec_t tbl [15];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic e; logic [WS-1:0] rd, xd; logic [31:0] ap; int ac, rc, hc, w0, e0;

    tbl[0]  = '{3'd0, 6'd0,  32'h0,        1'b0,   0, 32'h0,        1'b1};
    tbl[1]  = '{3'd4, 6'd5,  32'h0,        1'b0,   1, 32'hDEADBEEF, 1'b1};
    tbl[2]  = '{3'd5, 6'd0,  32'h12345678, 1'b0,   0, 32'h0,        1'b1};
    tbl[3]  = '{3'd4, 6'd0,  32'h0,        1'b0,   1, 32'h12345678, 1'b1};
    tbl[4]  = '{3'd4, 6'd63, 32'h0,        1'b0,   1, 32'h0000003F, 1'b1};
    tbl[5]  = '{3'd3, 6'd0,  32'h0,        1'b0,   2, 32'h0,        1'b1};
    tbl[6]  = '{3'd2, 6'd0,  32'h0,        1'b0,   0, 32'h0,        1'b1};
    tbl[7]  = '{3'd6, 6'd0,  32'hFFFFFFF0, !BP_EN, 0, 32'h0,        1'b1};
    tbl[8]  = '{3'd7, 6'd0,  32'h0,        1'b1,   0, 32'h0,        1'b1};
    tbl[9]  = '{3'd1, 6'd0,  32'h0,        1'b0,   0, 32'h0,        1'b0};
    tbl[10] = '{3'd4, 6'd5,  32'h0,        1'b1,   0, 32'h0,        1'b0};
    tbl[11] = '{3'd5, 6'd5,  32'h0BADF00D, 1'b1,   0, 32'h0,        1'b0};
    tbl[12] = '{3'd3, 6'd0,  32'h0,        1'b1,   0, 32'h0,        1'b0};
    tbl[13] = '{3'd0, 6'd0,  32'h0,        1'b0,   0, 32'h0,        1'b0};
    tbl[14] = '{3'd2, 6'd0,  32'h0,        1'b0,   0, 32'h0,        1'b1};

    // Reset and boot hold
    #12;
    reset_values("reset");
    @(negedge clk); #1;
    rst = 1'b0;
    boot_check();

    // Fill RAM through the host port (address i holds i; 5 gets DEADBEEF)
    for (int i = 0; i < 64; i++) begin
      w0 = we_cnt;
      send(3'd5, AW'(i), (i == 5) ? 32'hDEADBEEF : WS'(i), e, rd, ap, ac);
      book(3'd5, AW'(i), (i == 5) ? 32'hDEADBEEF : WS'(i), e, ac);
      if (i == 5) begin
        chk("memwr_err", {63'd0, e}, 64'd0);
        chk("memwr_rsp_pc", {32'd0, rd}, {32'd0, ap});
        chk("memwr_we_pulse", 64'(we_cnt - w0), 64'd1);
      end
    end

    // Table-driven vectors
    w0 = we_cnt;
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].op, tbl[i].addr, tbl[i].wdata, e, rd, ap, ac);
      xd = (tbl[i].kind == 0) ? ap : (tbl[i].kind == 1) ? tbl[i].data : ap + 32'd4;
      chk($sformatf("vec%0d_err", i), {63'd0, e}, {63'd0, tbl[i].err});
      chk($sformatf("vec%0d_data", i), {32'd0, rd}, {32'd0, xd});
      chk($sformatf("vec%0d_halted", i), {63'd0, halted}, {63'd0, tbl[i].hlt});
      book(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].err, ac);
    end
    chk("vec_ram_we_count", 64'(we_cnt - w0), 64'd1);
    chk("vec_cycle_cnt", {32'd0, cycle_cnt}, {32'd0, exp_cnt});

    // STEP from pc 0x10
    set_pc(32'h10);
    e0 = en_cnt;
    send(3'd3, 6'd0, 32'h0, e, rd, ap, ac);
    book(3'd3, 6'd0, 32'h0, 1'b0, ac);
    chk("step_err", {63'd0, e}, 64'd0);
    chk("step_rsp_pc", {32'd0, rd}, 64'h14);
    chk("step_pc", {32'd0, pc}, 64'h14);
    chk("step_halted", {63'd0, halted}, 64'd1);
    chk("step_en_cycles", 64'(en_cnt - e0), 64'd1);
    chk("step_cycle_cnt", {32'd0, cycle_cnt}, {32'd0, exp_cnt});

    // RUN about 10 cycles with the core storing, then HALT; stores stop when halted
    core_ram_we = 1'b1; core_ram_addr = 6'd9; core_ram_wdata = 32'hA5A5A5A5;
    w0 = we_cnt;
    set_pc(32'h100);
    send(3'd1, 6'd0, 32'h0, e, rd, ap, rc);
    book(3'd1, 6'd0, 32'h0, e, rc);
    repeat (8) @(negedge clk);
    send(3'd2, 6'd0, 32'h0, e, rd, ap, hc);
    book(3'd2, 6'd0, 32'h0, e, hc);
    chk("run_halt_rsp_pc", {32'd0, rd}, {32'd0, ap});
    chk("run_pc_advance", {32'd0, pc}, 64'(32'h100 + 32'(4 * (hc - rc))));
    repeat (5) @(negedge clk);
    chk("run_store_count", 64'(we_cnt - w0), 64'(hc - rc));
    chk("run_cycle_cnt", {32'd0, cycle_cnt}, {32'd0, exp_cnt});
    chk("halted_core_en", {63'd0, core_en}, 64'd0);
    ref_mem[9] = 32'hA5A5A5A5;
    core_ram_we = 1'b0;
    model_cmd(3'd4, 6'd9, 32'h0);

    // Randomized commands against the model
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (BP_EN && op == 3'd6) op = 3'd0;
      if (!m_run && ($urandom_range(0, 3) == 0)) set_pc(32'($urandom_range(64, 1024)) * 32'd4);
      model_cmd(op, 6'($urandom_range(0, 63)), $urandom);
    end
    if (m_run) model_cmd(3'd2, 6'd0, 32'h0);
    chk("rand_cycle_cnt", {32'd0, cycle_cnt}, {32'd0, exp_cnt});

`ifdef RUNCTRL_BREAKPOINT_EN
    // Breakpoint at 0x20, run from 0
    model_cmd(3'd6, 6'd0, 32'h20);
    set_pc(32'h0);
    model_cmd(3'd1, 6'd0, 32'h0);
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("bp_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("bp_rsp_data", {32'd0, rsp_data}, 64'h20);
    @(negedge clk);
    chk("bp_halted", {63'd0, halted}, 64'd1);
    chk("bp_pc", {32'd0, pc}, 64'h20);
    m_run = 1'b0;
    exp_cnt = exp_cnt + 32'd8;
    chk("bp_cycle_cnt", {32'd0, cycle_cnt}, {32'd0, exp_cnt});
`endif

    // Reset asserted in the middle of RUN
    set_pc(32'h400);
    model_cmd(3'd1, 6'd0, 32'h0);
    core_ram_we = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    reset_values("midrst");
    core_ram_we = 1'b0;
    m_run = 1'b0;
    exp_cnt = '0;
    @(negedge clk); #1;
    rst = 1'b0;
    boot_check();
    model_cmd(3'd4, 6'd5, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
